// File: rtl/gpio_in_conditioner_if.sv
// gpio_in_conditioner_if
//   Bundles the pad-side inputs and conditioned outputs of gpio_in_conditioner.
//   Signals:
//     PAD_IN  [IO_NUM]  raw asynchronous pad levels
//     DB_EN   [IO_NUM]  per-bit debounce enable (quasi-static)
//     GPIO_IN [IO_NUM]  conditioned level towards CoreGPIO GPIO_IN
//     RISE    [IO_NUM]  one-cycle pulse on each 0->1 change of GPIO_IN
//     FALL    [IO_NUM]  one-cycle pulse on each 1->0 change of GPIO_IN
//     TICK              prescaler sample strobe
//   Modports: master drives the pads/enables, slave is the conditioner.
interface gpio_in_conditioner_if #(
   parameter int unsigned IO_NUM = 8
);
   logic [IO_NUM-1:0] PAD_IN;
   logic [IO_NUM-1:0] DB_EN;
   logic [IO_NUM-1:0] GPIO_IN;
   logic [IO_NUM-1:0] RISE;
   logic [IO_NUM-1:0] FALL;
   logic              TICK;

   modport master (
      output PAD_IN,
      output DB_EN,
      input  GPIO_IN,
      input  RISE,
      input  FALL,
      input  TICK
   );

   modport slave (
      input  PAD_IN,
      input  DB_EN,
      output GPIO_IN,
      output RISE,
      output FALL,
      output TICK
   );
endinterface

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
//   Synchronises raw pad inputs into the SYSCLK_apb domain and debounces each bit
//   against a shared prescaled sample tick, giving CoreGPIO a clean GPIO_IN level
//   plus per-bit one-cycle rise/fall pulses.
//   Ports:
//     SYSCLK_apb  clock
//     PRESETN     asynchronous active-low reset
//     bus         gpio_in_conditioner_if.slave (PAD_IN, DB_EN in; GPIO_IN, RISE,
//                 FALL, TICK out)
module gpio_in_conditioner #(
   parameter int unsigned IO_NUM      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PRESCALE    = 100,
   parameter int unsigned DB_SAMPLES  = 4,
   parameter bit          RESET_LEVEL = 1'b0
) (
   input logic                  SYSCLK_apb,
   input logic                  PRESETN,
   gpio_in_conditioner_if.slave bus
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned CW = $clog2(DB_SAMPLES + 1);
   localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_SAMPLES - 1);
   localparam logic [IO_NUM-1:0] RST_VEC = {IO_NUM{RESET_LEVEL}};

   logic [PW-1:0]     pre_q, pre_d;
   logic              tick_q, tick_d;
   logic [IO_NUM-1:0] sync_q [SYNC_STAGES];
   logic [IO_NUM-1:0] sync_last;
   logic [IO_NUM-1:0] s_q, s_d;
   logic [IO_NUM-1:0] rise_q, rise_d;
   logic [IO_NUM-1:0] fall_q, fall_d;
   logic [CW-1:0]     cnt_q [IO_NUM];
   logic [CW-1:0]     cnt_d [IO_NUM];

   assign sync_last = sync_q[SYNC_STAGES-1];

   // Free-running prescaler; TICK is registered so it rises PRESCALE edges
   // after reset release and the debouncers act on the edge that follows.
   always_comb begin
      tick_d = (pre_q == PRE_MAX);
      pre_d  = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
   end

   always_comb begin
      s_d   = s_q;
      cnt_d = cnt_q;
      for (int i = 0; i < IO_NUM; i++) begin
         if (!bus.DB_EN[i]) begin
            // Bypass: follow the synchroniser and discard any partial count.
            s_d[i]   = sync_last[i];
            cnt_d[i] = '0;
         end else if (tick_q) begin
            if (sync_last[i] == s_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               s_d[i]   = sync_last[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      // Pulses are registered from the next state so they line up with the
      // first cycle GPIO_IN shows the new level.
      rise_d = s_d & ~s_q;
      fall_d = ~s_d & s_q;
   end

   always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
      if (!PRESETN) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
         s_q    <= RST_VEC;
         rise_q <= '0;
         fall_q <= '0;
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= RST_VEC;
         end
         for (int i = 0; i < IO_NUM; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         pre_q     <= pre_d;
         tick_q    <= tick_d;
         s_q       <= s_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         sync_q[0] <= bus.PAD_IN;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         cnt_q <= cnt_d;
      end
   end

   assign bus.GPIO_IN = s_q;
   assign bus.RISE    = rise_q;
   assign bus.FALL    = fall_q;
   assign bus.TICK    = tick_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner
//   Self-checking bench for gpio_in_conditioner with IO_NUM=8, SYNC_STAGES=2,
//   PRESCALE=4, DB_SAMPLES=3, RESET_LEVEL=0. Expected GPIO_IN transitions are
//   queued when stimulus is applied and compared when GPIO_IN changes.
module tb_gpio_in_conditioner;

   logic SYSCLK_apb;
   logic PRESETN;

   gpio_in_conditioner_if #(.IO_NUM(8)) bus ();

   gpio_in_conditioner #(
      .IO_NUM      (8),
      .SYNC_STAGES (2),
      .PRESCALE    (4),
      .DB_SAMPLES  (3),
      .RESET_LEVEL (1'b0)
   ) dut (
      .SYSCLK_apb (SYSCLK_apb),
      .PRESETN    (PRESETN),
      .bus        (bus)
   );

   typedef struct {
      int         lo;
      int         hi;
      logic [7:0] gpio;
      logic [7:0] rise;
      logic [7:0] fall;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   errors;

   initial SYSCLK_apb = 1'b0;
   always #5 SYSCLK_apb = ~SYSCLK_apb;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge SYSCLK_apb);
      #1;
   endtask

   // Steps until GPIO_IN changes or max_steps elapse; n is steps taken.
   task automatic wait_change(input int max_steps, output int n);
      logic [7:0] prev;
      prev = bus.GPIO_IN;
      n = 0;
      while (bus.GPIO_IN === prev && n < max_steps) begin
         step();
         n++;
      end
   endtask

   // Steps until TICK is observed high; ok=0 if it never appears.
   task automatic align_tick(output bit ok);
      int k;
      k = 0;
      while (bus.TICK !== 1'b1 && k < 10) begin
         step();
         k++;
      end
      ok = (bus.TICK === 1'b1);
   endtask

   task automatic test_reset();
      logic exp_tick;
      bus.PAD_IN = 8'hFF;
      bus.DB_EN  = 8'hFF;
      #2 PRESETN = 1'b0;
      repeat (3) step();
      checks++;
      if (bus.GPIO_IN !== 8'h00) begin
         errors++;
         $display("FAIL reset_gpio: got %h want 00", bus.GPIO_IN);
      end
      checks++;
      if (bus.RISE !== 8'h00) begin
         errors++;
         $display("FAIL reset_rise: got %h want 00", bus.RISE);
      end
      checks++;
      if (bus.FALL !== 8'h00) begin
         errors++;
         $display("FAIL reset_fall: got %h want 00", bus.FALL);
      end
      checks++;
      if (bus.TICK !== 1'b0) begin
         errors++;
         $display("FAIL reset_tick: got %b want 0", bus.TICK);
      end
      bus.PAD_IN = 8'h00;
      repeat (2) step();
      PRESETN = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         exp_tick = (k % 4 == 0);
         checks++;
         if (bus.TICK !== exp_tick) begin
            errors++;
            $display("FAIL tick_phase edge %0d: got %b want %b", k, bus.TICK, exp_tick);
         end
      end
   endtask

   task automatic test_bypass();
      exp_t e;
      int   n;
      bus.DB_EN  = 8'h00;
      bus.PAD_IN = 8'h5A;
      sb.push_back('{lo: 3, hi: 3, gpio: 8'h5A, rise: 8'h5A, fall: 8'h00});
      wait_change(10, n);
      e = sb.pop_front();
      checks++;
      if (n < e.lo || n > e.hi) begin
         errors++;
         $display("FAIL bypass_rise_latency: got %0d want %0d..%0d", n, e.lo, e.hi);
      end
      checks++;
      if (bus.GPIO_IN !== e.gpio || bus.RISE !== e.rise || bus.FALL !== e.fall) begin
         errors++;
         $display("FAIL bypass_rise_value: got g=%h r=%h f=%h want g=%h r=%h f=%h",
                  bus.GPIO_IN, bus.RISE, bus.FALL, e.gpio, e.rise, e.fall);
      end
      step();
      checks++;
      if (bus.RISE !== 8'h00 || bus.FALL !== 8'h00) begin
         errors++;
         $display("FAIL bypass_pulse_width: got r=%h f=%h want 00 00", bus.RISE, bus.FALL);
      end
      bus.PAD_IN = 8'h00;
      sb.push_back('{lo: 3, hi: 3, gpio: 8'h00, rise: 8'h00, fall: 8'h5A});
      wait_change(10, n);
      e = sb.pop_front();
      checks++;
      if (n < e.lo || n > e.hi || bus.GPIO_IN !== e.gpio || bus.RISE !== e.rise
          || bus.FALL !== e.fall) begin
         errors++;
         $display("FAIL bypass_fall: got n=%0d g=%h r=%h f=%h want n=%0d g=%h r=%h f=%h",
                  n, bus.GPIO_IN, bus.RISE, bus.FALL, e.lo, e.gpio, e.rise, e.fall);
      end
      step();
   endtask

   task automatic test_debounce_accept();
      exp_t e;
      int   n;
      bus.DB_EN  = 8'hFF;
      step();
      // sync lands 2 edges after the pad; acceptance is 9..12 edges after that.
      bus.PAD_IN = 8'h01;
      sb.push_back('{lo: 11, hi: 14, gpio: 8'h01, rise: 8'h01, fall: 8'h00});
      wait_change(30, n);
      e = sb.pop_front();
      checks++;
      if (n < e.lo || n > e.hi) begin
         errors++;
         $display("FAIL db_rise_latency: got %0d want %0d..%0d", n, e.lo, e.hi);
      end
      checks++;
      if (bus.GPIO_IN !== e.gpio || bus.RISE !== e.rise || bus.FALL !== e.fall) begin
         errors++;
         $display("FAIL db_rise_value: got g=%h r=%h f=%h want g=%h r=%h f=%h",
                  bus.GPIO_IN, bus.RISE, bus.FALL, e.gpio, e.rise, e.fall);
      end
      step();
      checks++;
      if (bus.RISE !== 8'h00) begin
         errors++;
         $display("FAIL db_rise_width: got %h want 00", bus.RISE);
      end
      bus.PAD_IN = 8'h00;
      sb.push_back('{lo: 11, hi: 14, gpio: 8'h00, rise: 8'h00, fall: 8'h01});
      wait_change(30, n);
      e = sb.pop_front();
      checks++;
      if (n < e.lo || n > e.hi || bus.GPIO_IN !== e.gpio || bus.RISE !== e.rise
          || bus.FALL !== e.fall) begin
         errors++;
         $display("FAIL db_fall: got n=%0d g=%h r=%h f=%h want n=%0d..%0d g=%h r=%h f=%h",
                  n, bus.GPIO_IN, bus.RISE, bus.FALL, e.lo, e.hi, e.gpio, e.rise, e.fall);
      end
      step();
      checks++;
      if (bus.FALL !== 8'h00) begin
         errors++;
         $display("FAIL db_fall_width: got %h want 00", bus.FALL);
      end
   endtask

   task automatic test_glitch_reject();
      int         n;
      bit         ok;
      logic [7:0] rise_seen;
      logic       pat [5];
      rise_seen = 8'h00;
      bus.PAD_IN = 8'h02;
      repeat (6) begin
         step();
         rise_seen |= bus.RISE;
      end
      bus.PAD_IN = 8'h00;
      wait_change(40, n);
      checks++;
      if (bus.GPIO_IN !== 8'h00 || rise_seen !== 8'h00) begin
         errors++;
         $display("FAIL glitch_short: got g=%h rise_seen=%h want 00 00",
                  bus.GPIO_IN, rise_seen);
      end
      // One pad value per tick period, each sampled by exactly one tick.
      pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
      align_tick(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL glitch_align: got TICK=%b want 1", bus.TICK);
      end
      for (int p = 0; p < 5; p++) begin
         bus.PAD_IN = {6'b0, pat[p], 1'b0};
         repeat (4) begin
            step();
            rise_seen |= bus.RISE;
         end
      end
      bus.PAD_IN = 8'h00;
      wait_change(40, n);
      checks++;
      if (bus.GPIO_IN !== 8'h00 || rise_seen !== 8'h00) begin
         errors++;
         $display("FAIL glitch_pattern: got g=%h rise_seen=%h want 00 00",
                  bus.GPIO_IN, rise_seen);
      end
   endtask

   task automatic test_enable_drop();
      exp_t e;
      int   n;
      bit   ok;
      bus.DB_EN = 8'hFF;
      align_tick(ok);
      bus.PAD_IN = 8'h04;
      // Tick edges at +1 (C stays 0), +5 (C=1), +9 (C=2); +13 would accept.
      repeat (9) step();
      checks++;
      if (!ok || bus.GPIO_IN !== 8'h00) begin
         errors++;
         $display("FAIL drop_precount: got g=%h aligned=%0d want 00 1", bus.GPIO_IN, ok);
      end
      bus.DB_EN = 8'hFB;
      sb.push_back('{lo: 1, hi: 1, gpio: 8'h04, rise: 8'h04, fall: 8'h00});
      wait_change(5, n);
      e = sb.pop_front();
      checks++;
      if (n < e.lo || n > e.hi || bus.GPIO_IN !== e.gpio || bus.RISE !== e.rise
          || bus.FALL !== e.fall) begin
         errors++;
         $display("FAIL drop_take: got n=%0d g=%h r=%h f=%h want n=%0d g=%h r=%h f=%h",
                  n, bus.GPIO_IN, bus.RISE, bus.FALL, e.lo, e.gpio, e.rise, e.fall);
      end
      step();
      checks++;
      if (bus.RISE !== 8'h00) begin
         errors++;
         $display("FAIL drop_single_rise: got %h want 00", bus.RISE);
      end
      bus.PAD_IN = 8'h00;
      bus.DB_EN  = 8'h00;
      repeat (4) step();
   endtask

   task automatic test_async_reset();
      exp_t e;
      int   n;
      bit   ok;
      bus.DB_EN  = 8'h00;
      bus.PAD_IN = 8'hA5;
      sb.push_back('{lo: 3, hi: 3, gpio: 8'hA5, rise: 8'hA5, fall: 8'h00});
      wait_change(10, n);
      e = sb.pop_front();
      checks++;
      if (n < e.lo || n > e.hi || bus.GPIO_IN !== e.gpio || bus.RISE !== e.rise) begin
         errors++;
         $display("FAIL arst_setup: got n=%0d g=%h r=%h want n=%0d g=%h r=%h",
                  n, bus.GPIO_IN, bus.RISE, e.lo, e.gpio, e.rise);
      end
      step();
      bus.DB_EN  = 8'hFF;
      bus.PAD_IN = 8'h5A;
      align_tick(ok);
      step();
      checks++;
      if (!ok || bus.GPIO_IN !== 8'hA5) begin
         errors++;
         $display("FAIL arst_premid: got g=%h aligned=%0d want A5 1", bus.GPIO_IN, ok);
      end
      PRESETN = 1'b0;
      #1;
      checks++;
      if (bus.GPIO_IN !== 8'h00 || bus.RISE !== 8'h00 || bus.FALL !== 8'h00
          || bus.TICK !== 1'b0) begin
         errors++;
         $display("FAIL arst_immediate: got g=%h r=%h f=%h t=%b want 00 00 00 0",
                  bus.GPIO_IN, bus.RISE, bus.FALL, bus.TICK);
      end
      repeat (2) step();
      PRESETN = 1'b1;
      // sync settles at edge 2, ticks sampled at edges 5, 9, 13.
      sb.push_back('{lo: 13, hi: 13, gpio: 8'h5A, rise: 8'h5A, fall: 8'h00});
      wait_change(20, n);
      e = sb.pop_front();
      checks++;
      if (n < e.lo || n > e.hi || bus.GPIO_IN !== e.gpio || bus.RISE !== e.rise
          || bus.FALL !== e.fall) begin
         errors++;
         $display("FAIL arst_relatch: got n=%0d g=%h r=%h f=%h want n=%0d g=%h r=%h f=%h",
                  n, bus.GPIO_IN, bus.RISE, bus.FALL, e.lo, e.gpio, e.rise, e.fall);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      PRESETN    = 1'b1;
      bus.PAD_IN = 8'h00;
      bus.DB_EN  = 8'h00;
      test_reset();
      test_bypass();
      test_debounce_accept();
      test_glitch_reject();
      test_enable_drop();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
